alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares the single 4-bit combinational ALU among N_REQ requesters.
//  Accepts {A,B,SEL} jobs over per-requester valid/ready, drives the ALU from registered operands,
//  captures result + flags, returns them on one valid/ready response channel tagged with requester ID.
//  One job in flight at a time; sits between requester logic and the ALU instance.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  ID_W    2  requester ID width, = clog2(N_REQ)
// PORTS
//  CLK          in   1        single clock, rising edge
//  RST          in   1        asynchronous, active-high reset
//  REQ_VALID    in   N_REQ    job valid per requester
//  REQ_READY    out  N_REQ    job accepted (one-hot or zero)
//  REQ_A        in   4*N_REQ  operand A, requester i at [4i+3:4i]
//  REQ_B        in   4*N_REQ  operand B, same packing
//  REQ_SEL      in   3*N_REQ  op select (000 add,001 sub,010 and,011 or,100 xor,101 nand,110 xnor,111 nor)
//  ALU_A/ALU_B  out  4        registered operands to ALU
//  ALU_SEL      out  3        registered op select to ALU
//  ALU_OUT      in   4        ALU result
//  ALU_FLAGS    in   4        {CARRY_OUT,OVERFLOW,ZERO,SIGNO} from ALU
//  RSP_VALID    out  1        response valid
//  RSP_READY    in   1        response consumer ready
//  RSP_ID       out  ID_W     requester that issued the job
//  RSP_RESULT   out  4        captured ALU result
//  RSP_FLAGS    out  4        captured {C,V,Z,S}
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, RR pointer=0, ALU_SEL=000, stats counter 0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: REQ_READY combinationally = one-hot grant of first REQ_VALID at/after pointer (wrapping);
//          on handshake latch A,B,SEL,ID into ALU_* regs, pointer <= grant_id+1 mod N_REQ, go EXEC.
//    EXEC: ALU settles; at cycle end capture ALU_OUT/ALU_FLAGS into RSP_* regs, go RESP.
//    RESP: RSP_VALID=1; RSP_* stable until RSP_READY=1; then go IDLE.
//  - REQ_READY=0 in EXEC/RESP; no new grant until response handshake completes.
//  - Latency: accept at cycle t, RSP_VALID at t+2; min throughput one job per 3 cycles.
//  - Requesters not granted keep REQ_VALID asserted; their payload is not sampled.
//  - Pointer only advances on grant; N_REQ simultaneous valids served in strict rotation.
//  - No valids in IDLE: stay IDLE, REQ_READY=0, ALU_* hold last values.
//  - Flags passed through unmodified; logic ops carry C=V=0 as produced by the ALU.
//  - RST mid-job: job discarded, no response, asynchronous return to reset state.
//  - ID_W != clog2(N_REQ) or N_REQ outside 2..8: elaboration error.
// CONFIGURATION
//  ALU_RR_SCHED_STATS_EN defined: adds STAT_CLR in 1 (sync clear) and STAT_OPS out 16 =
//   saturating count of completed response handshakes; saturates at 16'hFFFF; STAT_CLR wins over
//   increment in the same cycle.
//  Not defined: ports and counter absent; core behaviour identical.
// STRUCTURE
//  Package alu_rr_sched_pkg: FSM state enum (IDLE,EXEC,RESP), op-select constants for the 8 codes,
//   flag bit indices (C=3,V=2,Z=1,S=0).
//  Sub-module rr_arbiter (N_REQ; req, ptr -> one-hot gnt, gnt_id); rest stays in the top.
// TESTING
//  1) Req0: A=7,B=1,SEL=000 -> RSP_VALID at t+2, RESULT=8, FLAGS=0101 (V=1,S=1), RSP_ID=0.
//  2) Req2: A=3,B=5,SEL=001 -> RESULT=E, FLAGS=1001 (C=1,S=1), RSP_ID=2.
//  3) All 4 valid every cycle, RSP_READY=1 -> IDs served 0,1,2,3,0; one grant per 3 cycles.
//  4) Req1: A=A,B=5,SEL=010, RSP_READY low 5 cycles -> RESULT=0,FLAGS=0010 held stable; REQ_READY=0.
//  5) RST pulsed during EXEC -> no response, all outputs 0, next grant starts from requester 0.
//  6) STATS_EN: 3 jobs -> STAT_OPS=3; STAT_CLR with a handshake same cycle -> STAT_OPS=0.

Source files
------------

// File: rtl/alu_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// alu_rr_sched_pkg
// Shared definitions for the round-robin ALU scheduler:
//   - state_e   : scheduler FSM states (IDLE, EXEC, RESP)
//   - OP_*      : the eight ALU operation-select codes
//   - FLAG_*    : bit positions inside the {C,V,Z,S} flag nibble
// -----------------------------------------------------------------------------
package alu_rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first asserted request at or
// after the pointer, wrapping around.
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  ID_W   highest-priority requester index
//   gnt    out N_REQ  one-hot grant (all zero when no request)
//   gnt_id out ID_W   index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  // Scan requesters in priority order starting at ptr; the first hit wins.
  always_comb begin
    logic found_s;
    logic hit_s;
    int   idx_s;
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s       = (int'(ptr) + k) % N_REQ;
      hit_s       = !found_s && req[idx_s];
      gnt[idx_s]  = gnt[idx_s] | hit_s;
      gnt_id      = hit_s ? ID_W'(idx_s) : gnt_id;
      found_s     = found_s | hit_s;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one external 4-bit combinational ALU among N_REQ requesters.
// One job is in flight at a time: IDLE (grant) -> EXEC (ALU settles, result
// captured) -> RESP (response held until accepted) -> IDLE.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY   per-requester job handshake (READY one-hot or zero)
//   REQ_A/REQ_B/REQ_SEL   packed per-requester payloads (4/4/3 bits each)
//   ALU_A/ALU_B/ALU_SEL   registered operands driven to the ALU
//   ALU_OUT/ALU_FLAGS     ALU result and {C,V,Z,S}
//   RSP_VALID/RSP_READY   response handshake
//   RSP_ID/RSP_RESULT/RSP_FLAGS  captured response payload
// Optional (`ALU_RR_SCHED_STATS_EN defined):
//   STAT_CLR in  synchronous clear of the statistics counter
//   STAT_OPS out saturating count of completed response handshakes
// -----------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     REQ_VALID,
  output logic [N_REQ-1:0]     REQ_READY,
  input  logic [4*N_REQ-1:0]   REQ_A,
  input  logic [4*N_REQ-1:0]   REQ_B,
  input  logic [3*N_REQ-1:0]   REQ_SEL,
  output logic [3:0]           ALU_A,
  output logic [3:0]           ALU_B,
  output logic [2:0]           ALU_SEL,
  input  logic [3:0]           ALU_OUT,
  input  logic [3:0]           ALU_FLAGS,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [ID_W-1:0]      RSP_ID,
  output logic [3:0]           RSP_RESULT,
  output logic [3:0]           RSP_FLAGS
`ifdef ALU_RR_SCHED_STATS_EN
  ,
  input  logic                 STAT_CLR,
  output logic [15:0]          STAT_OPS
`endif
);

  // Reject unsupported configurations at elaboration time.
  generate
    if ((N_REQ < 2) || (N_REQ > 8) || (ID_W != $clog2(N_REQ))) begin : g_bad_cfg
      $error("alu_rr_scheduler: N_REQ must be 2..8 and ID_W must equal clog2(N_REQ)");
    end
  endgenerate

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   job_id_r;
  logic [3:0]        alu_a_r;
  logic [3:0]        alu_b_r;
  logic [2:0]        alu_sel_r;
  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [3:0]        rsp_result_r;
  logic [3:0]        rsp_flags_r;
  logic [N_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]   gnt_id_s;
  logic [N_REQ-1:0]  req_ready_s;
  logic              take_s;
  logic              rsp_hs_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (REQ_VALID),
    .ptr    (ptr_r),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign rsp_hs_s = (state_r == RESP) && RSP_READY;

  // Next-state and grant decode; grants are only offered while idle and out of reset.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = '0;
    take_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if ((|REQ_VALID) && !RST) begin
          req_ready_s = gnt_s;
          take_s      = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Job capture on grant: operands/op to the ALU, requester tag, pointer advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_a_r   <= 4'd0;
      alu_b_r   <= 4'd0;
      alu_sel_r <= 3'd0;
      job_id_r  <= '0;
      ptr_r     <= '0;
    end else if (take_s) begin
      alu_a_r   <= REQ_A[{gnt_id_s, 2'b00} +: 4];
      alu_b_r   <= REQ_B[{gnt_id_s, 2'b00} +: 4];
      alu_sel_r <= REQ_SEL[32'(gnt_id_s) * 32'd3 +: 3];
      job_id_r  <= gnt_id_s;
      ptr_r     <= (gnt_id_s == ID_W'(N_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
    end else begin
      alu_a_r   <= alu_a_r;
      alu_b_r   <= alu_b_r;
      alu_sel_r <= alu_sel_r;
      job_id_r  <= job_id_r;
      ptr_r     <= ptr_r;
    end
  end

  // Response capture at the end of EXEC; payload then holds until the next job completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= 4'd0;
      rsp_flags_r  <= 4'd0;
    end else if (state_r == EXEC) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= job_id_r;
      rsp_result_r <= ALU_OUT;
      rsp_flags_r  <= ALU_FLAGS;
    end else if (rsp_hs_s) begin
      rsp_valid_r  <= 1'b0;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
    end
  end

  assign REQ_READY  = req_ready_s;
  assign ALU_A      = alu_a_r;
  assign ALU_B      = alu_b_r;
  assign ALU_SEL    = alu_sel_r;
  assign RSP_VALID  = rsp_valid_r;
  assign RSP_ID     = rsp_id_r;
  assign RSP_RESULT = rsp_result_r;
  assign RSP_FLAGS  = rsp_flags_r;

`ifdef ALU_RR_SCHED_STATS_EN
  logic [15:0] stat_ops_r;

  // Completed-response counter: clear dominates, increment saturates at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_ops_r <= 16'd0;
    end else if (STAT_CLR) begin
      stat_ops_r <= 16'd0;
    end else if (rsp_hs_s && (stat_ops_r != 16'hFFFF)) begin
      stat_ops_r <= stat_ops_r + 16'd1;
    end else begin
      stat_ops_r <= stat_ops_r;
    end
  end

  assign STAT_OPS = stat_ops_r;
`endif

endmodule
